// File: rtl/dpu_sequencer_if.sv
// Bus bundle between the DPU sequencer, its program memory, the DPU datapath
// and the host that starts a program. The sequencer takes the master side.
interface dpu_sequencer_if;
  // host control and status
  logic        start;
  logic [7:0]  start_addr;
  logic        busy;
  logic        done;
  logic [7:0]  pc;

  // synchronous program memory port
  logic [7:0]  pm_addr;
  logic [23:0] pm_data;

  // DPU control inputs and condition code
  logic [3:0]  cc;
  logic [3:0]  Abus;
  logic [3:0]  Bbus;
  logic [3:0]  Rbus;
  logic [3:0]  n;
  logic [7:0]  mData;

  modport master (
    input  start, start_addr, pm_data, cc,
    output pm_addr, Abus, Bbus, Rbus, n, mData, busy, done, pc
  );

  modport slave (
    output start, start_addr, pm_data, cc,
    input  pm_addr, Abus, Bbus, Rbus, n, mData, busy, done, pc
  );
endinterface

// File: rtl/dpu_sequencer.sv
// Instruction sequencer feeding the DPU. Fetches 24-bit words from a
// synchronous program memory, issues DPU ops (0..10) for ISSUE_CYCLES cycles
// each and executes control ops (SETCNT, DJNZ, BZ, JMP, HALT) locally.
// Word layout: [23:20] op, [19:16] R, [15:12] A, [11:8] B, [7:0] imm.
module dpu_sequencer #(
  parameter int ISSUE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dpu_sequencer_if.master bus
);

  localparam int CW = (ISSUE_CYCLES > 1) ? $clog2(ISSUE_CYCLES) : 1;
  localparam logic [CW-1:0] ISSUE_LAST = CW'(ISSUE_CYCLES - 1);

  localparam logic [3:0] OP_LOAD     = 4'd8;
  localparam logic [3:0] OP_LAST_DPU = 4'd10;
  localparam logic [3:0] OP_SETCNT   = 4'd11;
  localparam logic [3:0] OP_DJNZ     = 4'd12;
  localparam logic [3:0] OP_BZ       = 4'd13;
  localparam logic [3:0] OP_JMP      = 4'd14;
  localparam logic [3:0] OP_NOP      = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      pc_reg, pc_next;
  logic [7:0]      loop_cnt_reg, loop_cnt_next;
  logic            z_reg, z_next;
  logic [3:0]      ctl_op_reg, ctl_op_next;
  logic [7:0]      ctl_imm_reg, ctl_imm_next;
  logic [CW-1:0]   issue_cnt_reg, issue_cnt_next;
  logic [3:0]      n_reg, n_next;
  logic [3:0]      a_reg, a_next;
  logic [3:0]      b_reg, b_next;
  logic [3:0]      r_reg, r_next;
  logic [7:0]      mdata_reg, mdata_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  // decoded fields of the word arriving from program memory during WAIT
  logic [3:0]      pm_op;
  logic [7:0]      pm_imm;
  logic [7:0]      cnt_dec;
  logic            unused_cc;

  assign pm_op     = bus.pm_data[23:20];
  assign pm_imm    = bus.pm_data[7:0];
  assign cnt_dec   = loop_cnt_reg - 8'd1;
  // only the Z bit of the condition code steers control flow
  assign unused_cc = ^{bus.cc[3], bus.cc[1:0]};

  // Next-state and datapath decisions; everything holds unless changed below.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    loop_cnt_next  = loop_cnt_reg;
    z_next         = z_reg;
    ctl_op_next    = ctl_op_reg;
    ctl_imm_next   = ctl_imm_reg;
    issue_cnt_next = issue_cnt_reg;
    n_next         = n_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    r_next         = r_reg;
    mdata_next     = mdata_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // a start coinciding with the done pulse belongs to the finished run
        if (bus.start && !done_reg) begin
          state_next = S_FETCH;
          pc_next    = bus.start_addr;
          busy_next  = 1'b1;
        end
      end

      S_FETCH: begin
        // pm_addr follows pc, so the memory sees the address this cycle
        state_next = S_WAIT;
      end

      S_WAIT: begin
        ctl_op_next  = pm_op;
        ctl_imm_next = pm_imm;
        if (pm_op <= OP_LAST_DPU) begin
          // DPU fields are loaded once here and held for the whole issue
          state_next     = S_ISSUE;
          issue_cnt_next = '0;
          n_next         = pm_op;
          r_next         = bus.pm_data[19:16];
          a_next         = bus.pm_data[15:12];
          b_next         = bus.pm_data[11:8];
          mdata_next     = (pm_op == OP_LOAD) ? pm_imm : 8'h00;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_ISSUE: begin
        if (issue_cnt_reg == ISSUE_LAST) begin
          // the DPU result has settled: capture Z and return to no-op
          state_next = S_FETCH;
          pc_next    = pc_reg + 8'd1;
          z_next     = bus.cc[2];
          n_next     = OP_NOP;
          r_next     = 4'h0;
          a_next     = 4'h0;
          b_next     = 4'h0;
          mdata_next = 8'h00;
        end else begin
          issue_cnt_next = issue_cnt_reg + 1'b1;
        end
      end

      S_EXEC: begin
        state_next = S_FETCH;
        case (ctl_op_reg)
          OP_SETCNT: begin
            loop_cnt_next = ctl_imm_reg;
            pc_next       = pc_reg + 8'd1;
          end
          OP_DJNZ: begin
            // a zero count wraps to 255 and therefore jumps
            loop_cnt_next = cnt_dec;
            pc_next       = (cnt_dec != 8'd0) ? ctl_imm_reg : pc_reg + 8'd1;
          end
          OP_BZ: begin
            pc_next = z_reg ? ctl_imm_reg : pc_reg + 8'd1;
          end
          OP_JMP: begin
            pc_next = ctl_imm_reg;
          end
          default: begin
            // HALT: pc stays on the HALT word for debug visibility
            state_next = S_IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        endcase
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Program counter, loop/flag registers and registered DPU outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg        <= 8'h00;
      loop_cnt_reg  <= 8'h00;
      z_reg         <= 1'b0;
      ctl_op_reg    <= OP_NOP;
      ctl_imm_reg   <= 8'h00;
      issue_cnt_reg <= '0;
      n_reg         <= OP_NOP;
      a_reg         <= 4'h0;
      b_reg         <= 4'h0;
      r_reg         <= 4'h0;
      mdata_reg     <= 8'h00;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      loop_cnt_reg  <= loop_cnt_next;
      z_reg         <= z_next;
      ctl_op_reg    <= ctl_op_next;
      ctl_imm_reg   <= ctl_imm_next;
      issue_cnt_reg <= issue_cnt_next;
      n_reg         <= n_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      r_reg         <= r_next;
      mdata_reg     <= mdata_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign bus.pm_addr = pc_reg;
  assign bus.pc      = pc_reg;
  assign bus.n       = n_reg;
  assign bus.Abus    = a_reg;
  assign bus.Bbus    = b_reg;
  assign bus.Rbus    = r_reg;
  assign bus.mData   = mdata_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_dpu_sequencer.sv
// Bench for dpu_sequencer: two instances (ISSUE_CYCLES 2 and 1) share one
// program memory image. An instruction-level model expands each program
// into the expected per-cycle output trace, which is compared to the DUT.
module tb_dpu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dpu_sequencer_if bus0 ();
  dpu_sequencer_if bus1 ();

  dpu_sequencer #(.ISSUE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  dpu_sequencer #(.ISSUE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  logic [23:0] mem [256];

  always @(posedge clk) begin
    bus0.pm_data <= mem[bus0.pm_addr];
    bus1.pm_data <= mem[bus1.pm_addr];
  end

  // DPU stand-in: Z is set whenever the issued A and B selects are equal
  assign bus0.cc = {1'b0, (bus0.Abus == bus0.Bbus), 2'b01};
  assign bus1.cc = {1'b0, (bus1.Abus == bus1.Bbus), 2'b01};

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic [7:0] md;
    logic [7:0] pc;
    logic [7:0] pma;
    logic       pv;
  } tr_t;

  tr_t exp_q [$];
  tr_t obs_q [$];
  int tests = 0;
  int fails = 0;
  logic       z_m   [2];
  logic [7:0] cnt_m [2];

  function automatic logic [23:0] ins(input logic [3:0] op, input logic [3:0] r,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [7:0] imm);
    return {op, r, a, b, imm};
  endfunction

  function automatic tr_t mk(input logic busy, input logic done, input logic [3:0] n,
                             input logic [3:0] a, input logic [3:0] b, input logic [3:0] r,
                             input logic [7:0] md, input logic [7:0] pc, input logic pv);
    tr_t t;
    t = '{busy, done, n, a, b, r, md, pc, (pv ? pc : 8'h00), pv};
    return t;
  endfunction

  function automatic tr_t sample(input int sel);
    tr_t t;
    if (sel == 0)
      t = '{bus0.busy, bus0.done, bus0.n, bus0.Abus, bus0.Bbus, bus0.Rbus, bus0.mData, bus0.pc, bus0.pm_addr, 1'b1};
    else
      t = '{bus1.busy, bus1.done, bus1.n, bus1.Abus, bus1.Bbus, bus1.Rbus, bus1.mData, bus1.pc, bus1.pm_addr, 1'b1};
    return t;
  endfunction

  // pm_addr is only meaningful while an instruction is being fetched
  function automatic tr_t view(input tr_t o, input logic pv);
    tr_t t;
    t = o;
    t.pv = pv;
    if (!pv) t.pma = 8'h00;
    return t;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] a);
    if (sel == 0) begin bus0.start = v; bus0.start_addr = a; end
    else          begin bus1.start = v; bus1.start_addr = a; end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin z_m[s] = 1'b0; cnt_m[s] = 8'h00; end
  endtask

  // Instruction-level interpreter that emits one trace entry per clock.
  task automatic model_run(input int sel, input logic [7:0] addr);
    logic [7:0]  pc;
    logic [23:0] w;
    logic [3:0]  op;
    logic        halted;
    int          k;
    k = (sel == 0) ? 2 : 1;
    exp_q.delete();
    pc = addr;
    halted = 1'b0;
    for (int steps = 0; steps < 300 && !halted; steps++) begin
      w  = mem[pc];
      op = w[23:20];
      exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, pc, 1'b1));
      exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, pc, 1'b1));
      if (op <= 4'd10) begin
        for (int c = 0; c < k; c++)
          exp_q.push_back(mk(1'b1, 1'b0, op, w[15:12], w[11:8], w[19:16],
                             (op == 4'd8) ? w[7:0] : 8'h00, pc, 1'b0));
        z_m[sel] = (w[15:12] == w[11:8]);
        pc = pc + 8'd1;
      end else begin
        exp_q.push_back(mk(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, pc, 1'b0));
        case (op)
          4'd11: begin cnt_m[sel] = w[7:0]; pc = pc + 8'd1; end
          4'd12: begin
            cnt_m[sel] = cnt_m[sel] - 8'd1;
            pc = (cnt_m[sel] != 8'd0) ? w[7:0] : pc + 8'd1;
          end
          4'd13: pc = z_m[sel] ? w[7:0] : pc + 8'd1;
          4'd14: pc = w[7:0];
          default: begin
            exp_q.push_back(mk(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, pc, 1'b0));
            halted = 1'b1;
          end
        endcase
      end
    end
  endtask

  // Starts one run and records the DUT outputs from the first FETCH cycle
  // through the done cycle (bounded). Optionally re-pulses start mid-run
  // or in the done cycle.
  task automatic dut_run(input int sel, input logic [7:0] addr, input int pulse_at,
                         input bit start_on_done);
    tr_t t;
    int  cyc;
    obs_q.delete();
    @(negedge clk);
    drive(sel, 1'b1, addr);
    @(negedge clk);
    cyc = 0;
    while (cyc < 1500) begin
      t = sample(sel);
      obs_q.push_back(t);
      if (t.done === 1'b1) begin
        drive(sel, start_on_done, 8'h77);
        break;
      end
      drive(sel, (cyc == pulse_at), 8'h77);
      cyc++;
      @(negedge clk);
    end
    $display("[TB] run sel=%0d addr=%02h: %0d cycles observed, %0d expected", sel, addr,
             obs_q.size(), exp_q.size());
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus0.n, bus0.busy, bus0.done, bus0.pm_addr, bus0.pc, bus0.Abus, bus0.Bbus, bus0.Rbus, bus0.mData}
        !== {4'hF, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00}) begin
      fails++;
      $display("FAIL reset_state0 got n=%h busy=%b done=%b pm=%h pc=%h A=%h B=%h R=%h md=%h req n=f zeros",
               bus0.n, bus0.busy, bus0.done, bus0.pm_addr, bus0.pc, bus0.Abus, bus0.Bbus, bus0.Rbus, bus0.mData);
    end
    tests++;
    if ({bus1.n, bus1.busy, bus1.done, bus1.pm_addr} !== {4'hF, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_state1 got n=%h busy=%b done=%b pm=%h req n=f busy=0 done=0 pm=00",
               bus1.n, bus1.busy, bus1.done, bus1.pm_addr);
    end
    rst_n = 1'b1;
    model_reset();

    // reset asserted while a DPU op is on the outputs
    mem[8'h08] = ins(4'd3, 4'd1, 4'd2, 4'd4, 8'h00);
    mem[8'h09] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    @(negedge clk);
    drive(0, 1'b1, 8'h08);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (bus0.n !== 4'hF) seen = 1;
      else @(negedge clk);
    end
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL reset_reach_issue got no issue within 20 cycles req issue");
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({bus0.n, bus0.busy, bus0.Rbus} !== {4'hF, 1'b0, 4'h0}) begin
      fails++;
      $display("FAIL reset_mid_issue got n=%h busy=%b R=%h req n=f busy=0 R=0", bus0.n, bus0.busy, bus0.Rbus);
    end
    rst_n = 1'b1;
    model_reset();

    // fresh start at 0x10; BZ right after reset must fall through (Z cleared)
    mem[8'h10] = ins(4'd13, 4'd0, 4'd0, 4'd0, 8'h18);
    mem[8'h11] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    mem[8'h18] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    model_run(0, 8'h10);
    dut_run(0, 8'h10, -1, 1'b0);
    tests++;
    if (obs_q[0].pma !== 8'h10) begin
      fails++;
      $display("FAIL reset_start_pm_addr got %h req 10", obs_q[0].pma);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL reset_start_len got %0d req %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_start_trace[%0d] got %h req %h", i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_load_halt();
    int n8, last_issue, done_idx;
    mem[8'h00] = ins(4'd8, 4'd9, 4'd3, 4'd4, 8'hA5);
    mem[8'h01] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    model_run(0, 8'h00);
    dut_run(0, 8'h00, -1, 1'b0);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL load_len got %0d req %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
        fails++;
        $display("FAIL load_trace[%0d] got %h req %h", i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
        break;
      end
    end
    n8 = 0; last_issue = -1; done_idx = -1;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].n === 4'd8 && obs_q[i].r === 4'd9 && obs_q[i].md === 8'hA5) begin
        n8++; last_issue = i;
      end
      if (obs_q[i].done === 1'b1 && done_idx < 0) done_idx = i;
    end
    tests++;
    if (n8 != 2) begin
      fails++;
      $display("FAIL load_issue_cycles got %0d req 2", n8);
    end
    tests++;
    if (done_idx - (last_issue + 1) != 3) begin
      fails++;
      $display("FAIL load_done_delay got %0d req 3", done_idx - (last_issue + 1));
    end
  endtask

  task automatic test_counted_loop();
    int issues;
    mem[8'h20] = ins(4'd11, 4'd0, 4'd0, 4'd0, 8'd3);
    mem[8'h21] = ins(4'd2, 4'd1, 4'd2, 4'd3, 8'h00);
    mem[8'h22] = ins(4'd12, 4'd0, 4'd0, 4'd0, 8'h21);
    mem[8'h23] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    model_run(0, 8'h20);
    dut_run(0, 8'h20, -1, 1'b0);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL loop_len got %0d req %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
        fails++;
        $display("FAIL loop_trace[%0d] got %h req %h", i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
        break;
      end
    end
    issues = 0;
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i].n === 4'd2 && obs_q[i-1].n === 4'hF) issues++;
    tests++;
    if (issues != 3) begin
      fails++;
      $display("FAIL loop_issue_count got %0d req 3", issues);
    end
    tests++;
    if (obs_q[obs_q.size()-1].pc !== 8'h23) begin
      fails++;
      $display("FAIL loop_halt_pc got %h req 23", obs_q[obs_q.size()-1].pc);
    end
    // loop_cnt ended at 0, so a DJNZ now wraps to 255 and jumps
    mem[8'h28] = ins(4'd12, 4'd0, 4'd0, 4'd0, 8'h2C);
    mem[8'h29] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    mem[8'h2C] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    model_run(0, 8'h28);
    dut_run(0, 8'h28, -1, 1'b0);
    tests++;
    if (obs_q[obs_q.size()-1].pc !== 8'h2C) begin
      fails++;
      $display("FAIL djnz_zero_wrap got halt pc %h req 2c", obs_q[obs_q.size()-1].pc);
    end
  endtask

  task automatic test_branch_zero();
    logic [7:0] want_pc [2];
    want_pc[0] = 8'h40;
    want_pc[1] = 8'h32;
    mem[8'h31] = ins(4'd13, 4'd0, 4'd0, 4'd0, 8'h40);
    mem[8'h32] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    mem[8'h40] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: A==B gives Z=1; pass 1: A!=B gives Z=0
      mem[8'h30] = ins(4'd1, 4'd5, 4'd6, (pass == 0) ? 4'd6 : 4'd7, 8'h00);
      model_run(0, 8'h30);
      dut_run(0, 8'h30, -1, 1'b0);
      tests++;
      if (obs_q.size() < 8 || obs_q[7].pma !== want_pc[pass]) begin
        fails++;
        $display("FAIL bz_next_fetch pass %0d got %h req %h", pass,
                 (obs_q.size() < 8) ? 8'hXX : obs_q[7].pma, want_pc[pass]);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        tests++;
        if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
          fails++;
          $display("FAIL bz_trace pass %0d [%0d] got %h req %h", pass, i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_wrap_ignored_start();
    mem[8'hF0] = ins(4'd14, 4'd0, 4'd0, 4'd0, 8'hFF);
    mem[8'hFF] = ins(4'd4, 4'd2, 4'd3, 4'd5, 8'h00);
    mem[8'h00] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    model_run(0, 8'hF0);
    dut_run(0, 8'hF0, 4, 1'b1);
    tests++;
    if (obs_q.size() < 8 || obs_q[7].pma !== 8'h00) begin
      fails++;
      $display("FAIL wrap_fetch got %h req 00", (obs_q.size() < 8) ? 8'hXX : obs_q[7].pma);
    end
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL wrap_len got %0d req %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
        fails++;
        $display("FAIL wrap_trace[%0d] got %h req %h", i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
        break;
      end
    end
    // start was held high across the done cycle: it must be ignored
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    tests++;
    if (bus0.busy !== 1'b0) begin
      fails++;
      $display("FAIL start_on_done busy got %b req 0", bus0.busy);
    end
    @(negedge clk);
    tests++;
    if ({bus0.busy, bus0.pc} !== {1'b0, 8'h00}) begin
      fails++;
      $display("FAIL start_on_done idle got busy=%b pc=%h req busy=0 pc=00", bus0.busy, bus0.pc);
    end
  endtask

  task automatic test_back_to_back();
    int ops, longest, run;
    mem[8'h50] = ins(4'd0, 4'd1, 4'd2, 4'd3, 8'h00);
    mem[8'h51] = ins(4'd5, 4'd4, 4'd4, 4'd4, 8'h00);
    mem[8'h52] = ins(4'd8, 4'd7, 4'd0, 4'd1, 8'h3C);
    mem[8'h53] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    model_run(1, 8'h50);
    dut_run(1, 8'h50, -1, 1'b0);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_len got %0d req %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_trace[%0d] got %h req %h", i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
        break;
      end
    end
    ops = 0; longest = 0; run = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].n !== 4'hF) begin
        run++;
        if (run == 1) ops++;
        if (run > longest) longest = run;
      end else begin
        run = 0;
      end
    end
    tests++;
    if (ops != 3 || longest != 1) begin
      fails++;
      $display("FAIL b2b_single_issue got ops=%0d longest=%0d req ops=3 longest=1", ops, longest);
    end
  endtask

  task automatic test_random();
    logic [7:0] base;
    int         len, kind, sel;
    for (int p = 0; p < 8; p++) begin
      sel  = p % 2;
      base = 8'($urandom_range(8'h60, 8'hA0));
      len  = $urandom_range(4, 10);
      for (int i = 0; i < len; i++) begin
        kind = $urandom_range(0, 9);
        if (kind <= 5)
          mem[base + 8'(i)] = ins(4'($urandom_range(0, 10)), 4'($urandom), 4'($urandom_range(0, 2)),
                                  4'($urandom_range(0, 2)), 8'($urandom));
        else if (kind == 6)
          mem[base + 8'(i)] = ins(4'd11, 4'd0, 4'd0, 4'd0, 8'($urandom_range(0, 3)));
        else
          // forward-only control flow keeps every random program finite
          mem[base + 8'(i)] = ins(4'(kind + 5), 4'd0, 4'd0, 4'd0,
                                  base + 8'($urandom_range(i + 1, len)));
      end
      mem[base + 8'(len)] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
      model_run(sel, base);
      dut_run(sel, base, -1, 1'b0);
      tests++;
      if (obs_q.size() != exp_q.size()) begin
        fails++;
        $display("FAIL random_len prog %0d got %0d req %0d", p, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        tests++;
        if (view(obs_q[i], exp_q[i].pv) !== exp_q[i]) begin
          fails++;
          $display("FAIL random_trace prog %0d [%0d] got %h req %h", p, i, view(obs_q[i], exp_q[i].pv), exp_q[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ins(4'd15, 4'd0, 4'd0, 4'd0, 8'h00);
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    model_reset();
    test_reset();
    test_load_halt();
    test_counted_loop();
    test_branch_zero();
    test_wrap_ignored_start();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout req completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dpu_sequencer.md
# dpu_sequencer

Instruction sequencer that sits directly upstream of the DPU. It fetches 24-bit instruction words from a synchronous program memory and drives the DPU's register-select, opcode and load-data inputs one instruction at a time. It samples the DPU condition code and executes control-flow instructions (jump, branch-on-zero, counted loop, halt) locally; these are never forwarded to the DPU.

## Interface
- `ISSUE_CYCLES`, default 2: cycles each DPU instruction is held on the outputs (≥1). This gives register-file and ALU settle time.
- `clk` in 1: sole clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin execution at `start_addr`. Honoured only in IDLE.
- `start_addr` in 8: first program address.
- `pm_addr` out 8: program memory address.
- `pm_data` in 24: instruction word, valid one cycle after `pm_addr`.
- `cc` in 4: DPU condition code, `{N,Z,C,V}`, so `cc[2]` is Z.
- `Abus` out 4: DPU A-operand register select.
- `Bbus` out 4: DPU B-operand register select.
- `Rbus` out 4: DPU result register select.
- `n` out 4: DPU opcode. 15 is the DPU no-op.
- `mData` out 8: load data for DPU `n==8`.
- `busy` out 1: high from accepted start until halt.
- `done` out 1: one-cycle pulse on halt.
- `pc` out 8: current program counter, for debug.

## Operation
- Instruction format: `[23:20]` op, `[19:16]` R, `[15:12]` A, `[11:8]` B, `[7:0]` imm.
- Ops 0–10 are DPU ops, forwarded unchanged. Op 8 is the load; `mData` = imm.
- Ops 11–15 are sequencer control:
  - 11 SETCNT: `loop_cnt` ← imm.
  - 12 DJNZ: `loop_cnt` ← `loop_cnt`−1; jump to imm if the decremented value ≠ 0, else fall through. DJNZ with `loop_cnt`=0 wraps it to 255 and jumps.
  - 13 BZ: jump to imm if the Z flag is set, else fall through.
  - 14 JMP: jump to imm unconditionally.
  - 15 HALT: stop.
- Z flag is a register. It captures `cc[2]` on the last ISSUE cycle of every DPU op and is unchanged by control ops.
- States:
  - IDLE: `start` → FETCH, with PC ← `start_addr`.
  - FETCH: drive `pm_addr` = PC → WAIT.
  - WAIT: register `pm_data` → ISSUE if op ≤ 10, else EXEC.
  - ISSUE: drive the fields for `ISSUE_CYCLES` cycles; then PC ← PC+1 → FETCH.
  - EXEC: update PC / `loop_cnt` → FETCH. HALT instead → IDLE, pulsing `done`.
- PC arithmetic is 8-bit and wraps 255 → 0.
- Outside ISSUE: `n` = 15, `Abus`/`Bbus`/`Rbus`/`mData` = 0. A DPU op therefore appears as exactly one change of `n` away from 15 and back.
- `start` while busy is ignored, and so is `start` in the same cycle as `done`.

## Timing
- Reset (`rst_n` low at an edge) forces the following, regardless of state (mid-ISSUE included):
  - state IDLE, PC 0, `loop_cnt` 0, Z 0;
  - `n` 15, `Abus`/`Bbus`/`Rbus`/`mData` 0;
  - `busy` 0, `done` 0, `pm_addr` 0.
- `busy` rises the cycle after `start` is sampled in IDLE. It falls in the same cycle `done` is high.
- DPU op: 2 + `ISSUE_CYCLES` cycles (4 at default). Fields change only on the first ISSUE edge and hold stable until ISSUE exits.
- Control op: 3 cycles (FETCH, WAIT, EXEC).
- `pm_addr` is stable from FETCH through WAIT. `pm_data` is sampled only at the end of WAIT.
- BZ uses the Z value registered from the most recent DPU op. It is never a combinational `cc` sample.

## Test plan
- Reset then idle:
  - Hold `rst_n` low 3 cycles mid-ISSUE → next cycle `n`=15 and `busy`=0.
  - Then `start` with `start_addr`=0x10 → `pm_addr`=0x10 one cycle later.
- Load then halt:
  - Program `{8,R=9,imm=0xA5}`, then HALT.
  - Expect `n`=8, `Rbus`=9, `mData`=0xA5 for exactly 2 cycles, then `n`=15.
  - `done` pulses 3 cycles after ISSUE ends; `busy` drops with it.
- Counted loop:
  - SETCNT 3; one ALU op; DJNZ back to the ALU op; HALT.
  - Expect the ALU op issued exactly 3 times, `loop_cnt` = 0 at halt, PC = HALT address.
- Branch on zero:
  - Op returns `cc`=4'b0100, then BZ 0x40 → next `pm_addr` = 0x40.
  - Repeat with `cc`=0 → next `pm_addr` = BZ address + 1.
- Wrap and ignored start:
  - JMP 0xFF, where 0xFF holds a DPU op → next fetch at 0x00.
  - Pulse `start` during this run → no restart; PC sequence unchanged.
- `ISSUE_CYCLES`=1 build: each DPU op takes exactly 3 cycles; `n` returns to 15 between back-to-back ops.
